// File: rtl/digit_serial_adder.sv
// Multi-cycle ripple-carry adder: DIGIT bits per clock, registered inter-digit carry.
// Define ADDSUB_EN to add the Sub port and subtract mode.
module digit_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef ADDSUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             V
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW   = DIGIT + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d, cout_q, cout_d, v_q, v_d;
    logic              sub_w;
    logic [DIGIT:0]    dsum;
    logic              cmsb;
    logic              last;
    logic [WIDTH-1:0]  acc_shift;

`ifdef ADDSUB_EN
    assign sub_w = Sub;
`else
    assign sub_w = 1'b0;
`endif

    always_comb begin
        dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + DW'(carry_q);
        // Carry into the digit MSB recovered from its sum bit: s = a ^ b ^ cin.
        cmsb      = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];
        acc_shift = (acc_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        last      = (cnt_q == CntW'(N - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        v_d     = v_q;

        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_d     = A;
                        b_d     = sub_w ? ~B : B;
                        carry_d = sub_w | Cin;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    acc_d   = acc_shift;
                    carry_d = dsum[DIGIT];
                    a_d     = a_q >> DIGIT;
                    b_d     = b_q >> DIGIT;
                    cnt_d   = cnt_q + CntW'(1);
                    if (last) begin
                        sum_d   = acc_shift;
                        cout_d  = dsum[DIGIT];
                        v_d     = cmsb ^ dsum[DIGIT];
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign in_ready  = (state_q == StIdle) && en;
    assign out_valid = (state_q == StDone) && en;
    assign Sum       = sum_q;
    assign Carry     = cout_q;
    assign V         = v_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Randomised self-checking bench for digit_serial_adder (16/4 instance plus an 8/8 instance).
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst, en;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, sub, carry, v;

    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, sum8;
    logic        carry8, v8;
    logic        cin8 = 1'b0;
    logic        sub8 = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Cin(cin),
`ifdef ADDSUB_EN
        .Sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .Sum(sum), .Carry(carry), .V(v)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .Cin(cin8),
`ifdef ADDSUB_EN
        .Sub(sub8),
`endif
        .out_valid(out_valid8), .out_ready(out_ready8), .Sum(sum8), .Carry(carry8), .V(v8)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain wide arithmetic on the operands as seen at transfer.
    task automatic model(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                         input logic si, output logic [15:0] s, output logic c,
                         output logic ov);
        logic [15:0] bb;
        logic [16:0] full;
        bb   = si ? ~bi : bi;
        full = {1'b0, ai} + {1'b0, bb} + 17'(si ? 1'b1 : ci);
        s    = full[15:0];
        c    = full[16];
        ov   = (ai[15] == bb[15]) && (full[15] != ai[15]);
    endtask

    task automatic send(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                        input logic si);
        int w = 0;
        while (!in_ready && w < 20) begin
            tick;
            w++;
        end
        check_eq("accept_ready", 32'(in_ready), 32'd1);
        a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    endtask

    task automatic finish_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                             input logic si, input int k0, input int exp_lat, input int hold);
        logic [15:0] es;
        logic        ec, ev;
        int          k = k0;
        while (!out_valid && k < 60) begin
            tick;
            k++;
        end
        check_eq("latency", 32'(k), 32'(exp_lat));
        model(ai, bi, ci, si, es, ec, ev);
        check_eq("sum", 32'(sum), 32'(es));
        check_eq("carry", 32'(carry), 32'(ec));
        check_eq("v", 32'(v), 32'(ev));
        for (int i = 0; i < hold; i++) begin
            tick;
            check_eq("hold_sum", 32'(sum), 32'(es));
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check_eq("back_to_idle", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                         input logic si, input int hold);
        send(ai, bi, ci, si);
        finish_op(ai, bi, ci, si, 0, 4, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [15:0] ra, rb;
        logic        rc, rs;
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_sum", 32'(sum), 32'd0);
        check_eq("rst_carry", 32'(carry), 32'd0);
        check_eq("rst_v", 32'(v), 32'd0);
        rst = 1'b0;
        tick;

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 3);

        // Two en=0 cycles mid-RUN stretch the latency from 4 to 6.
        send(16'hABCD, 16'h1357, 1'b0, 1'b0);
        tick;
        en = 1'b0;
        tick;
        tick;
        en = 1'b1;
        finish_op(16'hABCD, 16'h1357, 1'b0, 1'b0, 3, 6, 0);

        // en=0 in DONE gates out_valid and blocks the transfer.
        send(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
        k = 0;
        while (!out_valid && k < 60) begin
            tick;
            k++;
        end
        out_ready = 1'b1;
        en = 1'b0;
        #1;
        check_eq("en_off_valid", 32'(out_valid), 32'd0);
        tick;
        check_eq("en_off_in_ready", 32'(in_ready), 32'd0);
        check_eq("en_off_sum", 32'(sum), 32'h0000);
        check_eq("en_off_carry", 32'(carry), 32'd1);
        out_ready = 1'b0;
        en = 1'b1;
        #1;
        check_eq("en_on_valid", 32'(out_valid), 32'd1);
        finish_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 0, 0, 0);

        // Asynchronous reset mid-RUN discards the operation and clears the result.
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0);
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        tick;
        check_eq("prev_result_held", 32'(sum), 32'h5556);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_sum", 32'(sum), 32'd0);
        check_eq("mid_rst_carry", 32'(carry), 32'd0);
        check_eq("mid_rst_v", 32'(v), 32'd0);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        #1;
        rst = 1'b0;
        tick;
        do_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

`ifdef ADDSUB_EN
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
`endif

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
`ifdef ADDSUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            do_op(ra, rb, rc, rs, int'($urandom_range(0, 2)));
        end

        // Single-digit instance: RUN lasts one cycle.
        a8 = 8'hC8; b8 = 8'h64; in_valid8 = 1'b1;
        tick;
        in_valid8 = 1'b0;
        k = 0;
        while (!out_valid8 && k < 20) begin
            tick;
            k++;
        end
        check_eq("w8_latency", 32'(k), 32'd1);
        check_eq("w8_sum", 32'(sum8), 32'h2C);
        check_eq("w8_carry", 32'(carry8), 32'd1);
        check_eq("w8_v", 32'(v8), 32'd0);
        out_ready8 = 1'b1;
        tick;
        out_ready8 = 1'b0;
        check_eq("w8_idle", 32'(in_ready8), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle ripple-carry adder: adds two WIDTH-bit operands DIGIT bits per clock, carrying between digits through a registered carry, with valid/ready handshakes on both sides. It is the sequential, width-generic successor to the 1-bit full-adder cell and is used where a full-width combinational ripple chain is too long for the clock period. Optional subtract mode is compiled in by macro.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of DIGIT
- DIGIT, 4, bits added per cycle; N = WIDTH/DIGIT cycles per operation
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  global enable; low freezes all state and gates both handshakes
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands (= state IDLE & en)
- A  input  WIDTH  operand A, sampled at input transfer
- B  input  WIDTH  operand B, sampled at input transfer
- Cin  input  1  carry-in, sampled at input transfer
- Sub  input  1  subtract select, sampled at input transfer (only with ADDSUB_EN)
- out_valid  output  1  result present (= state DONE & en)
- out_ready  input  1  consumer takes result
- Sum  output  WIDTH  result register
- Carry  output  1  carry-out of the MSB
- V  output  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- States: IDLE, RUN, DONE. Every transition and register update requires en=1.
- IDLE: on in_valid & in_ready, latch A, B into operand shift registers and Cin into the carry register, clear digit counter, go to RUN.
- RUN: each cycle add the low DIGIT bits of both operand registers plus the carry register; shift the digit sum into an internal result accumulator (LSB digit first); update the carry register; shift the operands right by DIGIT; increment the counter. On the cycle that processes digit N-1, also compute the carry into bit WIDTH-1, then go to DONE.
- Entering DONE: copy the accumulator to Sum, the final carry to Carry, and carry-into-MSB XOR Carry to V. Sum/Carry/V change only on this edge and otherwise hold the previous result.
- DONE: on out_valid & out_ready go to IDLE. No new operands are accepted in RUN or DONE.
- Arithmetic: {Carry, Sum} = A + B + Cin, modulo 2^(WIDTH+1), identical to a WIDTH-bit ripple-carry chain of full adders.
- DIGIT = WIDTH is legal: N = 1 and RUN lasts one cycle.

## Timing
- Reset (asynchronous, any state): state IDLE; Sum=0, Carry=0, V=0; counter, carry and operand registers cleared. in_ready=en, out_valid=0. An operation in flight is discarded.
- Latency: input transfer at edge t; with en continuously high, out_valid rises after edge t+N. Each en=0 cycle in RUN adds exactly one cycle.
- Throughput: one result per N+2 cycles when out_ready is held high. IDLE→accept takes 1 cycle, RUN takes N cycles, and DONE with out_ready=1 takes 1 cycle.
- out_valid, Sum, Carry and V hold stable while out_ready=0.
- en=0 in DONE: out_valid drops to 0, Sum/Carry/V hold, and no transfer occurs. When en returns, out_valid is reasserted.

## Configuration
- ADDSUB_EN defined: the Sub port exists. When Sub=1 at input transfer, the block latches ~B in place of B and forces the initial carry to 1, ignoring Cin. The result is A − B; Carry=1 means no borrow, and V is the signed overflow of the subtraction. When Sub=0, behaviour is the normal add.
- ADDSUB_EN undefined: no Sub port, and the block performs add only.

## Test plan
- Default params: A=0xFFFF, B=0x0001, Cin=0, transfer at edge t → out_valid after edge t+4 with Sum=0x0000, Carry=1, V=0.
- A=0x7FFF, B=0x0001, Cin=0 → Sum=0x8000, Carry=0, V=1. A=0x1234, B=0x4321, Cin=1 → Sum=0x5556, Carry=0, V=0.
- en held low for 2 cycles mid-RUN → out_valid rises 6 cycles after the transfer, and the result is unchanged. out_ready held low for 3 cycles in DONE → Sum is stable, in_ready=0, and IDLE follows the first out_ready=1 edge.
- rst pulsed during RUN after a prior result of 0x5556 → Sum=0, Carry=0, V=0, out_valid=0 and in_ready=1 immediately. The next operation A=0x0003, B=0x0004 → Sum=0x0007.
- ADDSUB_EN defined, Sub=1: A=0x0005, B=0x0007 → Sum=0xFFFE, Carry=0. A=0x8000, B=0x0001 → Sum=0x7FFF, Carry=1, V=1.
- WIDTH=8, DIGIT=8: A=0xC8, B=0x64, Cin=0 → out_valid after 1 cycle of RUN, Sum=0x2C, Carry=1, V=0.
